// File: rtl/tt_um_register.sv
// 8x8 register file tile: one synchronous write port, one combinational read port.
// Entry 0 reads as zero and has no storage; rst_n is an active-high async reset.
module tt_um_register (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;

  logic              we;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [DATA_W-1:0] wdata, rdata;
  logic              wr_en;

  logic [NUM_REGS-1:1][DATA_W-1:0] regs_d, regs_q;

  assign we    = ui_in[7];
  assign waddr = ui_in[6:4];
  assign raddr = ui_in[3:1];
  assign wdata = uio_in;
  assign wr_en = ena && we && (waddr != '0);

  logic unused_rsv;
  assign unused_rsv = ui_in[0];

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++)
      if (wr_en && waddr == ADDR_W'(i)) regs_d[i] = wdata;
  end

  genvar g;
  generate
    for (g = 1; g < NUM_REGS; g++) begin : g_reg
      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) regs_q[g] <= '0;
        else       regs_q[g] <= regs_d[g];
      end
    end
  endgenerate

  // Read is a plain mux with no bypass: a same-address write shows up after the edge.
  always_comb begin
    rdata = '0;
    for (int i = 1; i < NUM_REGS; i++)
      if (raddr == ADDR_W'(i)) rdata = regs_q[i];
  end

  assign uo_out  = rdata;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_tt_um_register.sv
// Directed bench for tt_um_register: vector table plus hand sequences for RDW and async reset.
module tb_tt_um_register;
  logic       clk, rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

  int n_tests = 0;
  int n_fail  = 0;

  tt_um_register dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic       we;
    logic [2:0] waddr;
    logic [2:0] raddr;
    logic       rsv;
    logic [7:0] wdata;
    logic [7:0] exp;   // uo_out just after the clock edge
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic e, logic w, logic [2:0] wa, logic [2:0] ra,
                              logic rs, logic [7:0] wd, logic [7:0] ex);
    vec_t v;
    v.ena = e; v.we = w; v.waddr = wa; v.raddr = ra; v.rsv = rs; v.wdata = wd; v.exp = ex;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic drive(logic e, logic w, logic [2:0] wa, logic [2:0] ra, logic rs, logic [7:0] wd);
    ena = e;
    ui_in = {w, wa, ra, rs};
    uio_in = wd;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00);

    // Write/read all
    for (int r = 1; r < 8; r++) add(1, 1, 3'(r), 3'(r), 0, 8'h10 + 8'(r), 8'h10 + 8'(r));
    for (int r = 1; r < 8; r++) add(1, 0, 3'd0, 3'(r), 1, 8'hEE, 8'h10 + 8'(r));
    // Register 0 ignores writes
    add(1, 1, 3'd0, 3'd0, 0, 8'hFF, 8'h00);
    for (int r = 1; r < 8; r++) add(1, 0, 3'd0, 3'(r), 0, 8'h00, 8'h10 + 8'(r));
    // Write gating on reg 3
    add(1, 1, 3'd3, 3'd3, 0, 8'hAA, 8'hAA);
    add(1, 0, 3'd3, 3'd3, 0, 8'h55, 8'hAA);
    add(0, 1, 3'd3, 3'd3, 1, 8'h55, 8'hAA);
    add(1, 1, 3'd3, 3'd3, 0, 8'h55, 8'h55);
    // Last write wins, and ui_in[0] is ignored
    add(1, 1, 3'd6, 3'd6, 1, 8'h3C, 8'h3C);
    add(1, 1, 3'd6, 3'd6, 0, 8'h96, 8'h96);
    add(1, 1, 3'd5, 3'd5, 1, 8'h01, 8'h01);

    // Reset held: every address reads zero
    #2;
    for (int r = 0; r < 8; r++) begin
      drive(1'b1, 1'b0, 3'd0, 3'(r), 1'b0, 8'h00);
      #1 check($sformatf("reset_rd%0d", r), uo_out, 8'h00);
    end
    check("reset_uio_oe", uio_oe, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int r = 0; r < 8; r++) begin
      drive(1'b1, 1'b0, 3'd0, 3'(r), 1'b0, 8'h00);
      @(posedge clk); #1 check($sformatf("post_reset_rd%0d", r), uo_out, 8'h00);
    end

    foreach (vecs[i]) begin
      drive(vecs[i].ena, vecs[i].we, vecs[i].waddr, vecs[i].raddr, vecs[i].rsv, vecs[i].wdata);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), uo_out, vecs[i].exp);
      check($sformatf("vec%0d_uio_oe", i), uio_oe, 8'h00);
    end

    // Read-during-write on reg 5: old value before the edge, new after
    drive(1'b1, 1'b1, 3'd5, 3'd5, 1'b0, 8'h02);
    #1 check("rdw_before", uo_out, 8'h01);
    @(posedge clk); #1 check("rdw_after", uo_out, 8'h02);
    drive(1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 8'h00);
    #1 check("rdw_other", uo_out, 8'h14);

    // Async reset mid-cycle wipes contents before any edge
    drive(1'b1, 1'b1, 3'd7, 3'd7, 1'b0, 8'hC3);
    @(posedge clk); #1 check("load7", uo_out, 8'hC3);
    drive(1'b1, 1'b0, 3'd0, 3'd7, 1'b0, 8'h00);
    #2 rst_n = 1'b1;
    #1 check("async_clear", uo_out, 8'h00);
    drive(1'b1, 1'b1, 3'd7, 3'd7, 1'b0, 8'h5A);
    @(posedge clk); #1 check("write_in_reset", uo_out, 8'h00);
    check("reset_uio_out2", uio_out, 8'h00);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 3'd0, 3'd7, 1'b0, 8'h00);
    @(posedge clk); #1 check("after_reset7", uo_out, 8'h00);
    drive(1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 8'h00);
    #1 check("after_reset3", uo_out, 8'h00);
    drive(1'b1, 1'b1, 3'd2, 3'd2, 1'b0, 8'h77);
    @(posedge clk); #1 check("write_after_reset", uo_out, 8'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
